activate_diff_pipe: RTL and testbench

ACTIVATE_DIFF_PIPE -- requirements
Module: activate_diff_pipe

---
 rtl/activate_diff_pkg.sv | 16 +
 rtl/pipe_fifo_mem.sv | 21 ++
 rtl/activate_diff_pipe.sv | 101 ++++++++++
 tb/tb_activate_diff_pipe.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/activate_diff_pkg.sv
// Shared widths and helpers for the activate_diff_pipe buffer.
package activate_diff_pkg;
  localparam int DEF_SIZE            = 3;
  localparam int DEF_DATA_SIZE       = 16;
  localparam int DEF_COST_TYPE_SIZE  = 8;
  localparam int DEF_DENSE_TYPE_SIZE = 4;
  localparam int DEF_DEPTH           = 2;
  localparam int MAX_DEPTH           = 16;
  localparam int IDX_W               = 32;
  localparam int STALL_W             = 16;

  // A single-entry buffer still needs a 1-bit pointer to index storage.
  function automatic int ptr_width(input int d);
    return (d > 1) ? $clog2(d) : 1;
  endfunction
endpackage

// File: rtl/pipe_fifo_mem.sv
// Payload storage: one synchronous write port, asynchronous read of the head entry.
module pipe_fifo_mem #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2,
  parameter int PTR_W = 1
) (
  input  logic             clk,
  input  logic             i_we,
  input  logic [PTR_W-1:0] i_wr_ptr,
  input  logic [WIDTH-1:0] i_wr_data,
  input  logic [PTR_W-1:0] i_rd_ptr,
  output logic [WIDTH-1:0] o_rd_data
);
  logic [WIDTH-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_wr_ptr] <= i_wr_data;
  end

  assign o_rd_data = r_mem[i_rd_ptr];
endmodule

// File: rtl/activate_diff_pipe.sv
// Valid/ready FIFO carrying one activate-diff request per entry.
// A push happens when in_valid && in_ready, a pop when out_valid && out_ready; flush beats both.
module activate_diff_pipe
  import activate_diff_pkg::*;
#(
  parameter int size            = DEF_SIZE,
  parameter int data_size       = DEF_DATA_SIZE,
  parameter int cost_type_size  = DEF_COST_TYPE_SIZE,
  parameter int dense_type_size = DEF_DENSE_TYPE_SIZE,
  parameter int depth           = DEF_DEPTH
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [data_size*size-1:0]    label,
  input  logic [cost_type_size-1:0]    cost_type,
  input  logic [dense_type_size-1:0]   dense_type,
  input  logic                         backprop_cost,
  input  logic [data_size*size-1:0]    w,
  input  logic [data_size*size-1:0]    x,
  input  logic [data_size*size-1:0]    z,
  input  logic [IDX_W-1:0]             w_layer_index,
  input  logic [IDX_W-1:0]             w_row_index,
  input  logic                         is_update,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [data_size*size-1:0]    label_out,
  output logic [cost_type_size-1:0]    cost_type_out,
  output logic [dense_type_size-1:0]   dense_type_out,
  output logic                         backprop_cost_out,
  output logic [data_size*size-1:0]    w_out,
  output logic [data_size*size-1:0]    x_out,
  output logic [data_size*size-1:0]    z_out,
  output logic [IDX_W-1:0]             w_layer_index_out,
  output logic [IDX_W-1:0]             w_row_index_out,
  output logic                         is_update_out,
  input  logic                         flush,
  output logic [$clog2(depth+1)-1:0]   occupancy,
  output logic [STALL_W-1:0]           stall_count
);
  localparam int VW    = size * data_size;
  localparam int PW    = 4 * VW + cost_type_size + dense_type_size + 2 + 2 * IDX_W;
  localparam int PTR_W = ptr_width(depth);
  localparam int OCC_W = $clog2(depth + 1);
  localparam logic [PTR_W-1:0] LAST_PTR  = PTR_W'(depth - 1);
  localparam logic [OCC_W-1:0] DEPTH_OCC = OCC_W'(depth);

  generate
    if (depth < 1 || depth > MAX_DEPTH) begin : g_bad_depth
      $error("activate_diff_pipe: depth must be within 1..16");
    end
  endgenerate

  logic [PTR_W-1:0]   r_wr_ptr, r_rd_ptr;
  logic [OCC_W-1:0]   r_occ;
  logic [STALL_W-1:0] r_stall;
  logic               w_push, w_pop, w_stall;
  logic [PW-1:0]      w_wr_data, w_rd_data, w_head;

  assign in_ready  = (r_occ < DEPTH_OCC);
  assign out_valid = (r_occ != '0);
  assign w_push    = in_valid && in_ready && !flush;
  assign w_pop     = out_valid && out_ready && !flush;
  assign w_stall   = out_valid && !out_ready;

  assign w_wr_data = {label, cost_type, dense_type, backprop_cost, w, x, z,
                      w_layer_index, w_row_index, is_update};

  pipe_fifo_mem #(.WIDTH(PW), .DEPTH(depth), .PTR_W(PTR_W)) u_mem (
    .clk       (clk),
    .i_we      (w_push),
    .i_wr_ptr  (r_wr_ptr),
    .i_wr_data (w_wr_data),
    .i_rd_ptr  (r_rd_ptr),
    .o_rd_data (w_rd_data)
  );

  // Storage is not reset, so stale contents are masked whenever nothing is held.
  assign w_head = out_valid ? w_rd_data : '0;
  assign {label_out, cost_type_out, dense_type_out, backprop_cost_out, w_out, x_out, z_out,
          w_layer_index_out, w_row_index_out, is_update_out} = w_head;

  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_occ    <= '0;
      r_stall  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= (r_wr_ptr == LAST_PTR) ? '0 : r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= (r_rd_ptr == LAST_PTR) ? '0 : r_rd_ptr + PTR_W'(1);
      if (w_push && !w_pop)      r_occ <= r_occ + OCC_W'(1);
      else if (w_pop && !w_push) r_occ <= r_occ - OCC_W'(1);
      if (w_stall && r_stall != '1) r_stall <= r_stall + STALL_W'(1);
    end
  end

  assign occupancy   = r_occ;
  assign stall_count = r_stall;
endmodule

// File: tb/tb_activate_diff_pipe.sv
// Directed scoreboard bench for activate_diff_pipe: a depth-2 and a depth-3 instance share payload inputs.
module tb_activate_diff_pipe;
  localparam int SIZE = 3, DS = 16, CTS = 8, DTS = 4;
  localparam int VW = SIZE * DS;
  localparam int PW = 4 * VW + CTS + DTS + 2 + 64;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // ---------------- shared payload ----------------
  logic [PW-1:0]  p_in;
  logic [VW-1:0]  label, w, x, z;
  logic [CTS-1:0] cost_type;
  logic [DTS-1:0] dense_type;
  logic           backprop_cost, is_update;
  logic [31:0]    wli, wri;
  assign {label, cost_type, dense_type, backprop_cost, w, x, z, wli, wri, is_update} = p_in;

  // ---------------- instance a (depth 2) ----------------
  logic a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_flush;
  logic [VW-1:0]  a_label_out, a_w_out, a_x_out, a_z_out;
  logic [CTS-1:0] a_cost_type_out;
  logic [DTS-1:0] a_dense_type_out;
  logic           a_bp_out, a_upd_out;
  logic [31:0]    a_wli_out, a_wri_out;
  logic [1:0]     a_occ;
  logic [15:0]    a_stall;
  logic [PW-1:0]  a_pk;
  assign a_pk = {a_label_out, a_cost_type_out, a_dense_type_out, a_bp_out, a_w_out, a_x_out,
                 a_z_out, a_wli_out, a_wri_out, a_upd_out};

  activate_diff_pipe #(.depth(2)) dut_a (
    .clk(clk), .rst_n(rst_n), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .label(label), .cost_type(cost_type), .dense_type(dense_type), .backprop_cost(backprop_cost),
    .w(w), .x(x), .z(z), .w_layer_index(wli), .w_row_index(wri), .is_update(is_update),
    .out_valid(a_out_valid), .out_ready(a_out_ready),
    .label_out(a_label_out), .cost_type_out(a_cost_type_out), .dense_type_out(a_dense_type_out),
    .backprop_cost_out(a_bp_out), .w_out(a_w_out), .x_out(a_x_out), .z_out(a_z_out),
    .w_layer_index_out(a_wli_out), .w_row_index_out(a_wri_out), .is_update_out(a_upd_out),
    .flush(a_flush), .occupancy(a_occ), .stall_count(a_stall)
  );

  // ---------------- instance b (depth 3) ----------------
  logic b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_flush;
  logic [VW-1:0]  b_label_out, b_w_out, b_x_out, b_z_out;
  logic [CTS-1:0] b_cost_type_out;
  logic [DTS-1:0] b_dense_type_out;
  logic           b_bp_out, b_upd_out;
  logic [31:0]    b_wli_out, b_wri_out;
  logic [1:0]     b_occ;
  logic [15:0]    b_stall;
  logic [PW-1:0]  b_pk;
  assign b_pk = {b_label_out, b_cost_type_out, b_dense_type_out, b_bp_out, b_w_out, b_x_out,
                 b_z_out, b_wli_out, b_wri_out, b_upd_out};

  activate_diff_pipe #(.depth(3)) dut_b (
    .clk(clk), .rst_n(rst_n), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .label(label), .cost_type(cost_type), .dense_type(dense_type), .backprop_cost(backprop_cost),
    .w(w), .x(x), .z(z), .w_layer_index(wli), .w_row_index(wri), .is_update(is_update),
    .out_valid(b_out_valid), .out_ready(b_out_ready),
    .label_out(b_label_out), .cost_type_out(b_cost_type_out), .dense_type_out(b_dense_type_out),
    .backprop_cost_out(b_bp_out), .w_out(b_w_out), .x_out(b_x_out), .z_out(b_z_out),
    .w_layer_index_out(b_wli_out), .w_row_index_out(b_wri_out), .is_update_out(b_upd_out),
    .flush(b_flush), .occupancy(b_occ), .stall_count(b_stall)
  );

  // ---------------- scoreboard ----------------
  logic [PW-1:0] a_q[$];
  logic [PW-1:0] b_q[$];
  int n_pass = 0, n_total = 0, b_rx = 0;

  task automatic chk(input string nm, input logic [PW-1:0] act, input logic [PW-1:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
  endtask

  function automatic logic [PW-1:0] mk(input int k);
    logic [15:0] b;
    b = 16'(k);
    return {{3{b * 16'd7 + 16'd1}}, 8'h10 + b[7:0], b[3:0], b[0],
            b * 16'd3 + 16'd3, b * 16'd3 + 16'd2, b * 16'd3 + 16'd1,
            {3{16'hA000 + b}}, {3{16'h5000 + b}}, 32'(k), 32'h100 + 32'(k), ~b[0]};
  endfunction

  // Monitor: compare the head against the expected queue on every handshake.
  always @(negedge clk) begin
    if (rst_n) begin
      if (a_out_valid && a_out_ready) begin
        if (a_q.size() == 0) chk("a_unexpected_pop", PW'(1), PW'(0));
        else chk("a_pop", a_pk, a_q.pop_front());
      end
      if (b_out_valid && b_out_ready) begin
        b_rx++;
        if (b_q.size() == 0) chk("b_unexpected_pop", PW'(1), PW'(0));
        else chk("b_pop", b_pk, b_q.pop_front());
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic push_a(input logic [PW-1:0] p);
    logic acc;
    p_in = p;
    a_in_valid = 1'b1;
    @(negedge clk);
    acc = a_in_ready;
    cyc();
    a_in_valid = 1'b0;
    if (acc) a_q.push_back(p);
  endtask

  task automatic push_b(input logic [PW-1:0] p);
    logic acc;
    int budget;
    p_in = p;
    b_in_valid = 1'b1;
    acc = 1'b0;
    budget = 0;
    while (!acc && budget < 100) begin
      @(negedge clk);
      acc = b_in_ready;
      cyc();
      budget++;
    end
    b_in_valid = 1'b0;
    if (acc) b_q.push_back(p);
    else chk("b_push_timeout", PW'(0), PW'(1));
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------
  initial begin
    int changes;
    int wait_c;
    p_in = '0;
    a_in_valid = 0; a_out_ready = 0; a_flush = 0;
    b_in_valid = 0; b_out_ready = 0; b_flush = 0;
    repeat (3) cyc();
    chk("rst_occ", PW'(a_occ), PW'(0));
    chk("rst_out_valid", PW'(a_out_valid), PW'(0));
    chk("rst_in_ready", PW'(a_in_ready), PW'(1));
    chk("rst_stall", PW'(a_stall), PW'(0));
    chk("rst_out_zero", a_pk, PW'(0));
    rst_n = 1'b1;
    cyc();

    // First push lands at the outputs one cycle later.
    a_out_ready = 1'b1;
    push_a(mk(0));
    chk("lat_valid", PW'(a_out_valid), PW'(1));
    chk("lat_w_out", PW'(a_w_out), PW'(48'h0003_0002_0001));
    chk("lat_occ", PW'(a_occ), PW'(1));
    cyc();
    chk("lat_drained", PW'(a_occ), PW'(0));

    // Fill to depth 2, third push is dropped.
    a_out_ready = 1'b0;
    push_a(mk(1));
    chk("fill1_in_ready", PW'(a_in_ready), PW'(1));
    push_a(mk(2));
    chk("fill2_in_ready", PW'(a_in_ready), PW'(0));
    chk("fill2_occ", PW'(a_occ), PW'(2));
    push_a(mk(3));
    chk("fill3_occ", PW'(a_occ), PW'(2));
    chk("fill3_head", a_pk, mk(1));
    chk("fill3_stall", PW'(a_stall), PW'(2));
    a_out_ready = 1'b1;
    repeat (2) cyc();
    a_out_ready = 1'b0;
    chk("fill_drained", PW'(a_occ), PW'(0));

    // Depth-3 streaming across pointer wrap with a random out_ready pattern.
    fork
      begin
        for (int k = 0; k < 10; k++) push_b(mk(k));
      end
      begin
        for (int c = 0; c < 60; c++) begin
          b_out_ready = 1'($urandom_range(0, 1));
          cyc();
        end
        b_out_ready = 1'b1;
      end
    join
    wait_c = 0;
    while (b_rx < 10 && wait_c < 50) begin
      cyc();
      wait_c++;
    end
    chk("stream_count", PW'(b_rx), PW'(10));
    chk("stream_occ", PW'(b_occ), PW'(0));

    // Flush of a full buffer drops the concurrent push.
    push_a(mk(20));
    push_a(mk(21));
    repeat (3) cyc();
    chk("pre_flush_stall", PW'(a_stall), PW'(6));
    p_in = mk(22);
    a_in_valid = 1'b1;
    a_flush = 1'b1;
    cyc();
    a_in_valid = 1'b0;
    a_flush = 1'b0;
    a_q.delete();
    chk("flush_occ", PW'(a_occ), PW'(0));
    chk("flush_valid", PW'(a_out_valid), PW'(0));
    chk("flush_stall", PW'(a_stall), PW'(0));
    chk("flush_in_ready", PW'(a_in_ready), PW'(1));
    a_out_ready = 1'b1;
    repeat (2) cyc();
    a_out_ready = 1'b0;
    chk("flush_absent", PW'(a_occ), PW'(0));

    // Long stall saturates the counter while the head stays put.
    push_a(mk(40));
    changes = 0;
    for (int i = 0; i < 70000; i++) begin
      @(negedge clk);
      if (a_pk !== mk(40) || a_out_valid !== 1'b1) changes++;
    end
    chk("stall_sat", PW'(a_stall), PW'(16'hFFFF));
    chk("stall_stable", PW'(changes), PW'(0));
    cyc();
    a_out_ready = 1'b1;
    cyc();
    a_out_ready = 1'b0;
    chk("stall_pop_occ", PW'(a_occ), PW'(0));
    chk("stall_hold_sat", PW'(a_stall), PW'(16'hFFFF));

    // Reset mid-stream beats a concurrent push.
    push_a(mk(50));
    push_a(mk(51));
    chk("mid_occ", PW'(a_occ), PW'(2));
    rst_n = 1'b0;
    p_in = mk(52);
    a_in_valid = 1'b1;
    cyc();
    a_in_valid = 1'b0;
    a_q.delete();
    chk("mid_rst_occ", PW'(a_occ), PW'(0));
    chk("mid_rst_valid", PW'(a_out_valid), PW'(0));
    chk("mid_rst_in_ready", PW'(a_in_ready), PW'(1));
    chk("mid_rst_stall", PW'(a_stall), PW'(0));
    chk("mid_rst_out_zero", a_pk, PW'(0));
    rst_n = 1'b1;
    repeat (2) cyc();
    chk("post_rst_occ", PW'(a_occ), PW'(0));

    chk("a_q_empty", PW'(a_q.size()), PW'(0));
    chk("b_q_empty", PW'(b_q.size()), PW'(0));
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
